// File: rtl/ssm_pkg.sv
// Shared types and sizing helpers for the SSM tile scheduler slice.
package ssm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_STALL = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } sched_state_e;

    // Width of an index that must hold 0..n-1; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int tiles(input int n_total, input int n_tile);
        return (n_total + n_tile - 1) / n_tile;
    endfunction

    function automatic int h_w(input int h);
        return idx_w(h);
    endfunction

    function automatic int p_w(input int p);
        return idx_w(p);
    endfunction

    function automatic int nb_w(input int n_total);
        return idx_w(n_total);
    endfunction

    function automatic int hp_w(input int h, input int p);
        return idx_w(h * p);
    endfunction

endpackage

// File: rtl/ssm_tile_scheduler_if.sv
// Control, tile-issue and y-writeback signals between the scheduler and
// SSMBLOCK_TOP / the y_out memory wrapper.
interface ssm_tile_scheduler_if
    import ssm_pkg::*;
#(
    parameter int DW      = 16,
    parameter int H       = 24,
    parameter int P       = 64,
    parameter int N_TOTAL = 128
);
    localparam int H_W  = h_w(H);
    localparam int P_W  = p_w(P);
    localparam int NB_W = nb_w(N_TOTAL);
    localparam int HP_W = hp_w(H, P);

    logic            start_i;
    logic            busy_o;
    logic            done_o;
    logic            tile_valid_o;
    logic            tile_ready_i;
    logic [H_W-1:0]  h_o;
    logic [P_W-1:0]  p_o;
    logic [NB_W-1:0] n_base_o;
    logic            tile_last_o;
    logic            y_valid_i;
    logic [DW-1:0]   y_i;
    logic            y_we_o;
    logic [HP_W-1:0] y_addr_o;
    logic [DW-1:0]   y_data_o;
    logic            err_underflow_o;

    modport master (
        input  start_i, tile_ready_i, y_valid_i, y_i,
        output busy_o, done_o, tile_valid_o, h_o, p_o, n_base_o, tile_last_o,
               y_we_o, y_addr_o, y_data_o, err_underflow_o
    );

    modport slave (
        output start_i, tile_ready_i, y_valid_i, y_i,
        input  busy_o, done_o, tile_valid_o, h_o, p_o, n_base_o, tile_last_o,
               y_we_o, y_addr_o, y_data_o, err_underflow_o
    );

endinterface

// File: rtl/ssm_tag_fifo.sv
// In-flight group tag FIFO. Power-of-two depth so the pointers wrap for free;
// a push while full is accepted only when a pop frees the slot that cycle.
module ssm_tag_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [W-1:0]           push_data,
    input  logic                   pop,
    output logic [W-1:0]           pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    // Tag storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ssm_tile_scheduler.sv
// Walks every (h,p) pair in blocked order, streams its state tiles to
// SSMBLOCK_TOP and writes each returning y_final to y_out[h*P+p].
//
// state | meaning
// IDLE  | waiting for start_i
// ISSUE | presenting tiles; group start gated on free tag slot
// STALL | group start blocked by a full tag FIFO, tile_valid_o low
// DRAIN | all tiles issued, waiting for the last y write to pop
// DONE  | one-cycle done_o, back to IDLE
module ssm_tile_scheduler
    import ssm_pkg::*;
#(
    parameter int DW        = 16,
    parameter int H         = 24,
    parameter int P         = 64,
    parameter int N_TOTAL   = 128,
    parameter int N_TILE    = 64,
    parameter int H_BLK     = 1,
    parameter int P_BLK     = 1,
    parameter int TAG_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    ssm_tile_scheduler_if.master bus
);
    localparam int TILES = tiles(N_TOTAL, N_TILE);
    localparam int H_W   = h_w(H);
    localparam int P_W   = p_w(P);
    localparam int NB_W  = nb_w(N_TOTAL);
    localparam int HP_W  = hp_w(H, P);
    localparam int T_W   = idx_w(TILES);
    localparam int CNT_W = $clog2(TAG_DEPTH) + 1;

    sched_state_e state_q;
    sched_state_e state_d;

    logic [H_W-1:0]   h_blk_q;
    logic [H_W-1:0]   h_rel_q;
    logic [P_W-1:0]   p_blk_q;
    logic [P_W-1:0]   p_rel_q;
    logic [T_W-1:0]   t_q;
    logic [NB_W-1:0]  n_base_q;

    logic [H_W-1:0]   h_cur;
    logic [P_W-1:0]   p_cur;
    logic             tile_first;
    logic             tile_last;
    logic             last_group;
    logic             can_group;
    logic             tile_valid;
    logic             busy;
    logic             done;
    logic             handshake;

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [HP_W-1:0]  tag_push;
    logic [HP_W-1:0]  tag_head;

    logic             y_we_q;
    logic [HP_W-1:0]  y_addr_q;
    logic [DW-1:0]    y_data_q;
    logic             err_q;

    assign h_cur      = h_blk_q + h_rel_q;
    assign p_cur      = p_blk_q + p_rel_q;
    assign tile_first = (t_q == '0);
    assign tile_last  = (t_q == T_W'(TILES - 1));
    assign last_group = (h_blk_q == H_W'(H - H_BLK)) && (h_rel_q == H_W'(H_BLK - 1)) &&
                        (p_blk_q == P_W'(P - P_BLK)) && (p_rel_q == P_W'(P_BLK - 1));

    // A pop in the same cycle frees a slot, so a full FIFO does not block then.
    assign fifo_pop   = bus.y_valid_i && !fifo_empty;
    assign can_group  = !fifo_full || fifo_pop;
    assign handshake  = tile_valid && bus.tile_ready_i;
    assign fifo_push  = handshake && tile_last;
    assign tag_push   = HP_W'(h_cur) * HP_W'(P) + HP_W'(p_cur);

    ssm_tag_fifo #(
        .W     (HP_W),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (tag_push),
        .pop       (fifo_pop),
        .pop_data  (tag_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control outputs.
    always_comb begin
        state_d    = state_q;
        busy       = 1'b0;
        done       = 1'b0;
        tile_valid = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start_i) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                busy       = 1'b1;
                tile_valid = !tile_first || can_group;
                if (tile_first && !can_group) begin
                    state_d = ST_STALL;
                end else if (bus.tile_ready_i && tile_last && last_group) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_STALL: begin
                busy = 1'b1;
                if (can_group) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (fifo_count == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Loop counters: t innermost, then p_rel, h_rel, p_blk, h_blk; all wrap to
    // zero after the final group so the next scan starts clean.
    always_ff @(posedge clk) begin
        if (rst || (state_q == ST_IDLE && bus.start_i)) begin
            h_blk_q  <= '0;
            h_rel_q  <= '0;
            p_blk_q  <= '0;
            p_rel_q  <= '0;
            t_q      <= '0;
            n_base_q <= '0;
        end else if (handshake) begin
            if (!tile_last) begin
                t_q      <= t_q + T_W'(1);
                n_base_q <= n_base_q + NB_W'(N_TILE);
            end else begin
                t_q      <= '0;
                n_base_q <= '0;
                if (p_rel_q != P_W'(P_BLK - 1)) begin
                    p_rel_q <= p_rel_q + P_W'(1);
                end else begin
                    p_rel_q <= '0;
                    if (h_rel_q != H_W'(H_BLK - 1)) begin
                        h_rel_q <= h_rel_q + H_W'(1);
                    end else begin
                        h_rel_q <= '0;
                        if (p_blk_q != P_W'(P - P_BLK)) begin
                            p_blk_q <= p_blk_q + P_W'(P_BLK);
                        end else begin
                            p_blk_q <= '0;
                            if (h_blk_q != H_W'(H - H_BLK)) begin
                                h_blk_q <= h_blk_q + H_W'(H_BLK);
                            end else begin
                                h_blk_q <= '0;
                            end
                        end
                    end
                end
            end
        end
    end

    // Writeback: runs in every state so late results still land after DRAIN
    // begins; an orphan y_valid_i only raises the sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_we_q   <= 1'b0;
            y_addr_q <= '0;
            y_data_q <= '0;
            err_q    <= 1'b0;
        end else begin
            y_we_q <= fifo_pop;
            if (fifo_pop) begin
                y_addr_q <= tag_head;
                y_data_q <= bus.y_i;
            end
            if (bus.y_valid_i && fifo_empty) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.busy_o          = busy;
    assign bus.done_o          = done;
    assign bus.tile_valid_o    = tile_valid;
    assign bus.h_o             = h_cur;
    assign bus.p_o             = p_cur;
    assign bus.n_base_o        = n_base_q;
    assign bus.tile_last_o     = tile_last && (state_q == ST_ISSUE);
    assign bus.y_we_o          = y_we_q;
    assign bus.y_addr_o        = y_addr_q;
    assign bus.y_data_o        = y_data_q;
    assign bus.err_underflow_o = err_q;

endmodule

// File: tb/tb_ssm_tile_scheduler.sv
// Directed bench for ssm_tile_scheduler: three instances (basic, shallow tag
// FIFO, blocked 4x4) checked against scoreboard queues of expected tiles/writes.
module tb_ssm_tile_scheduler;

    typedef struct {
        int h;
        int p;
        int nb;
        int last;
    } tile_t;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ssm_tile_scheduler_if #(.DW(16), .H(2), .P(2), .N_TOTAL(128)) ifa ();
    ssm_tile_scheduler_if #(.DW(16), .H(2), .P(2), .N_TOTAL(128)) ifb ();
    ssm_tile_scheduler_if #(.DW(16), .H(4), .P(4), .N_TOTAL(128)) ifc ();

    ssm_tile_scheduler #(.DW(16), .H(2), .P(2), .N_TOTAL(128), .N_TILE(64),
                         .H_BLK(1), .P_BLK(1), .TAG_DEPTH(16))
        dut_a (.clk(clk), .rst(rst), .bus(ifa.master));
    ssm_tile_scheduler #(.DW(16), .H(2), .P(2), .N_TOTAL(128), .N_TILE(64),
                         .H_BLK(1), .P_BLK(1), .TAG_DEPTH(2))
        dut_b (.clk(clk), .rst(rst), .bus(ifb.master));
    ssm_tile_scheduler #(.DW(16), .H(4), .P(4), .N_TOTAL(128), .N_TILE(64),
                         .H_BLK(2), .P_BLK(2), .TAG_DEPTH(16))
        dut_c (.clk(clk), .rst(rst), .bus(ifc.master));

    tile_t qa[$];
    tile_t qb[$];
    tile_t qc[$];
    wr_t   wa[$];
    wr_t   wb[$];
    wr_t   wc[$];
    int    echo_due[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int hs_a = 0, hs_b = 0, hs_c = 0;
    int done_a = 0, done_b = 0, done_c = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: monitor at the falling edge, return #1 after the rising edge.
    task automatic step();
        tile_t e;
        wr_t   w;
        @(negedge clk);
        if (ifa.tile_valid_o && ifa.tile_ready_i) begin
            hs_a++;
            chk("a_tile_pending", 32'(qa.size() > 0), 1);
            if (qa.size() > 0) begin
                e = qa.pop_front();
                chk("a_h", 32'(ifa.h_o), e.h);
                chk("a_p", 32'(ifa.p_o), e.p);
                chk("a_nb", 32'(ifa.n_base_o), e.nb);
                chk("a_last", 32'(ifa.tile_last_o), e.last);
            end
        end
        if (ifb.tile_valid_o && ifb.tile_ready_i) begin
            hs_b++;
            chk("b_tile_pending", 32'(qb.size() > 0), 1);
            if (qb.size() > 0) begin
                e = qb.pop_front();
                chk("b_h", 32'(ifb.h_o), e.h);
                chk("b_p", 32'(ifb.p_o), e.p);
                chk("b_nb", 32'(ifb.n_base_o), e.nb);
                chk("b_last", 32'(ifb.tile_last_o), e.last);
            end
        end
        if (ifc.tile_valid_o && ifc.tile_ready_i) begin
            hs_c++;
            chk("c_tile_pending", 32'(qc.size() > 0), 1);
            if (qc.size() > 0) begin
                e = qc.pop_front();
                chk("c_h", 32'(ifc.h_o), e.h);
                chk("c_p", 32'(ifc.p_o), e.p);
                chk("c_nb", 32'(ifc.n_base_o), e.nb);
                chk("c_last", 32'(ifc.tile_last_o), e.last);
                if (e.last != 0) echo_due.push_back(cyc + 30);
            end
        end
        if (ifa.y_we_o) begin
            chk("a_write_pending", 32'(wa.size() > 0), 1);
            if (wa.size() > 0) begin
                w = wa.pop_front();
                chk("a_y_addr", 32'(ifa.y_addr_o), w.addr);
                chk("a_y_data", 32'(ifa.y_data_o), w.data);
            end
        end
        if (ifb.y_we_o) begin
            chk("b_write_pending", 32'(wb.size() > 0), 1);
            if (wb.size() > 0) begin
                w = wb.pop_front();
                chk("b_y_addr", 32'(ifb.y_addr_o), w.addr);
                chk("b_y_data", 32'(ifb.y_data_o), w.data);
            end
        end
        if (ifc.y_we_o) begin
            chk("c_write_pending", 32'(wc.size() > 0), 1);
            if (wc.size() > 0) begin
                w = wc.pop_front();
                chk("c_y_addr", 32'(ifc.y_addr_o), w.addr);
                chk("c_y_data", 32'(ifc.y_data_o), w.data);
            end
        end
        if (ifa.done_o) done_a++;
        if (ifb.done_o) done_b++;
        if (ifc.done_o) done_c++;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic fill_a();
        for (int h = 0; h < 2; h++)
            for (int p = 0; p < 2; p++)
                for (int t = 0; t < 2; t++)
                    qa.push_back('{h, p, t * 64, int'(t == 1)});
    endtask

    task automatic fill_b();
        for (int h = 0; h < 2; h++)
            for (int p = 0; p < 2; p++)
                for (int t = 0; t < 2; t++)
                    qb.push_back('{h, p, t * 64, int'(t == 1)});
    endtask

    task automatic y_a(input int addr, input int data);
        wa.push_back('{addr, data});
        ifa.y_valid_i = 1'b1;
        ifa.y_i       = 16'(data);
        step();
        ifa.y_valid_i = 1'b0;
    endtask

    task automatic y_b(input int addr, input int data);
        wb.push_back('{addr, data});
        ifb.y_valid_i = 1'b1;
        ifb.y_i       = 16'(data);
        step();
        ifb.y_valid_i = 1'b0;
    endtask

    task automatic wait_done_a(input int bound);
        int d0 = done_a;
        for (int i = 0; i < bound && done_a == d0; i++) step();
        chk("a_done_seen", 32'(done_a - d0), 1);
    endtask

    task automatic wait_done_b(input int bound);
        int d0 = done_b;
        for (int i = 0; i < bound && done_b == d0; i++) step();
        chk("b_done_seen", 32'(done_b - d0), 1);
    endtask

    task automatic run_a_scan();
        ifa.start_i = 1'b1;
        step();
        ifa.start_i = 1'b0;
    endtask

    initial begin
        int exp_order[16] = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};
        int g;
        int d0;
        int h0;

        rst = 1'b1;
        ifa.start_i = 1'b0; ifa.tile_ready_i = 1'b0; ifa.y_valid_i = 1'b0; ifa.y_i = '0;
        ifb.start_i = 1'b0; ifb.tile_ready_i = 1'b0; ifb.y_valid_i = 1'b0; ifb.y_i = '0;
        ifc.start_i = 1'b0; ifc.tile_ready_i = 1'b0; ifc.y_valid_i = 1'b0; ifc.y_i = '0;
        repeat (3) step();

        // reset values
        chk("rst_busy", 32'(ifa.busy_o), 0);
        chk("rst_done", 32'(ifa.done_o), 0);
        chk("rst_valid", 32'(ifa.tile_valid_o), 0);
        chk("rst_last", 32'(ifa.tile_last_o), 0);
        chk("rst_we", 32'(ifa.y_we_o), 0);
        chk("rst_err", 32'(ifa.err_underflow_o), 0);
        chk("rst_hpn", 32'({ifa.h_o, ifa.p_o, ifa.n_base_o}), 0);
        chk("rst_addr_data", 32'({ifa.y_addr_o, ifa.y_data_o}), 0);
        rst = 1'b0;
        step();

        // 1: full-rate issue, 8 consecutive valid cycles, then drain
        fill_a();
        ifa.tile_ready_i = 1'b1;
        hs_a = 0;
        run_a_scan();
        chk("a_busy_after_start", 32'(ifa.busy_o), 1);
        for (int i = 0; i < 8; i++) begin
            chk("a_valid_run", 32'(ifa.tile_valid_o), 1);
            step();
        end
        chk("a_valid_end", 32'(ifa.tile_valid_o), 0);
        chk("a_hs_total", 32'(hs_a), 8);
        y_a(0, 16'h0100);
        chk("a_we_latency", 32'(ifa.y_we_o), 1);
        y_a(1, 16'h0101);
        y_a(2, 16'h0102);
        y_a(3, 16'h0103);
        chk("a_last_we", 32'(ifa.y_we_o), 1);
        chk("a_done_not_yet", 32'(ifa.done_o), 0);
        step();
        chk("a_done_after_we", 32'(ifa.done_o), 1);
        chk("a_busy_falls", 32'(ifa.busy_o), 0);
        step();
        chk("a_idle_busy", 32'(ifa.busy_o), 0);

        // 2: ready low on valid cycles 2..4
        fill_a();
        hs_a = 0;
        run_a_scan();
        for (int c = 0; c < 11; c++) begin
            ifa.tile_ready_i = !(c >= 2 && c <= 4);
            if (c >= 2 && c <= 5) begin
                chk("a_hold_valid", 32'(ifa.tile_valid_o), 1);
                chk("a_hold_hpn", 32'({ifa.h_o, ifa.p_o, ifa.n_base_o}), 32'({1'b0, 1'b1, 7'd0}));
            end
            step();
        end
        ifa.tile_ready_i = 1'b1;
        chk("a_hs_with_gaps", 32'(hs_a), 8);
        for (int k = 0; k < 4; k++) y_a(k, 16'h0200 + k);
        wait_done_a(20);

        // 3: TAG_DEPTH=2 stalls after two groups until a y returns
        fill_b();
        ifb.tile_ready_i = 1'b1;
        hs_b = 0;
        ifb.start_i = 1'b1;
        step();
        ifb.start_i = 1'b0;
        repeat (6) step();
        chk("b_hs_before_stall", 32'(hs_b), 4);
        chk("b_stall_valid", 32'(ifb.tile_valid_o), 0);
        chk("b_stall_busy", 32'(ifb.busy_o), 1);
        y_b(0, 16'h3C00);
        chk("b_we", 32'(ifb.y_we_o), 1);
        chk("b_we_addr", 32'(ifb.y_addr_o), 0);
        chk("b_we_data", 32'(ifb.y_data_o), 32'h3C00);
        chk("b_resume_valid", 32'(ifb.tile_valid_o), 1);
        for (int k = 1; k < 4; k++) begin
            step();
            step();
            y_b(k, 16'h3C00 + k);
        end
        wait_done_b(20);
        chk("b_hs_total", 32'(hs_b), 8);
        chk("b_no_err", 32'(ifb.err_underflow_o), 0);

        // 4: blocked 4x4 order with y echoed 30 cycles after each group
        for (int hb = 0; hb < 4; hb += 2)
            for (int pb = 0; pb < 4; pb += 2)
                for (int hr = 0; hr < 2; hr++)
                    for (int pr = 0; pr < 2; pr++)
                        for (int t = 0; t < 2; t++)
                            qc.push_back('{hb + hr, pb + pr, t * 64, int'(t == 1)});
        ifc.tile_ready_i = 1'b1;
        hs_c = 0;
        g = 0;
        d0 = done_c;
        ifc.start_i = 1'b1;
        step();
        ifc.start_i = 1'b0;
        for (int i = 0; i < 300 && done_c == d0; i++) begin
            if (echo_due.size() > 0 && echo_due[0] <= cyc && g < 16) begin
                void'(echo_due.pop_front());
                wc.push_back('{exp_order[g], 16'h1000 + g});
                ifc.y_valid_i = 1'b1;
                ifc.y_i       = 16'(16'h1000 + g);
                g++;
            end else begin
                ifc.y_valid_i = 1'b0;
            end
            step();
        end
        ifc.y_valid_i = 1'b0;
        repeat (10) step();
        chk("c_done_once", 32'(done_c - d0), 1);
        chk("c_hs_total", 32'(hs_c), 32);
        chk("c_echo_count", 32'(g), 16);
        chk("c_writes_left", 32'(wc.size()), 0);

        // 5: orphan y in IDLE
        ifa.y_valid_i = 1'b1;
        ifa.y_i       = 16'h1234;
        step();
        ifa.y_valid_i = 1'b0;
        chk("a_orphan_no_we", 32'(ifa.y_we_o), 0);
        chk("a_err_set", 32'(ifa.err_underflow_o), 1);
        repeat (3) step();
        chk("a_err_sticky", 32'(ifa.err_underflow_o), 1);

        // 6: rst mid-scan, then a clean rescan
        d0 = done_a;
        fill_a();
        run_a_scan();
        repeat (3) step();
        rst = 1'b1;
        step();
        chk("mid_rst_busy", 32'(ifa.busy_o), 0);
        chk("mid_rst_valid", 32'(ifa.tile_valid_o), 0);
        chk("mid_rst_last", 32'(ifa.tile_last_o), 0);
        chk("mid_rst_we", 32'(ifa.y_we_o), 0);
        chk("mid_rst_err", 32'(ifa.err_underflow_o), 0);
        chk("mid_rst_hpn", 32'({ifa.h_o, ifa.p_o, ifa.n_base_o}), 0);
        chk("mid_rst_addr_data", 32'({ifa.y_addr_o, ifa.y_data_o}), 0);
        rst = 1'b0;
        qa.delete();
        fill_a();
        hs_a = 0;
        run_a_scan();
        chk("rescan_valid", 32'(ifa.tile_valid_o), 1);
        chk("rescan_hpn", 32'({ifa.h_o, ifa.p_o, ifa.n_base_o}), 0);
        repeat (8) step();
        for (int k = 0; k < 4; k++) y_a(k, 16'h0300 + k);
        wait_done_a(20);
        chk("rescan_done_once", 32'(done_a - d0), 1);

        // 7: start_i while busy is ignored
        d0 = done_a;
        h0 = hs_a;
        fill_a();
        run_a_scan();
        step();
        step();
        ifa.start_i = 1'b1;
        step();
        ifa.start_i = 1'b0;
        repeat (5) step();
        for (int k = 0; k < 4; k++) y_a(k, 16'h0400 + k);
        wait_done_a(20);
        repeat (10) step();
        chk("rebusy_done_once", 32'(done_a - d0), 1);
        chk("rebusy_hs", 32'(hs_a - h0), 8);
        chk("rebusy_idle_valid", 32'(ifa.tile_valid_o), 0);

        chk("a_tiles_left", 32'(qa.size()), 0);
        chk("b_tiles_left", 32'(qb.size()), 0);
        chk("c_tiles_left", 32'(qc.size()), 0);
        chk("a_writes_left", 32'(wa.size()), 0);
        chk("b_writes_left", 32'(wb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
